// File: rtl/muldiv_pkg.sv
// Shared constants and state encoding for the MULT/DIV sequencer.
package muldiv_pkg;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration over {acc, q}: shift-add multiply step or restoring divide step.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum    = {1'b0, acc_i} + {1'b0, b_i};
    rem_sh = {acc_i, q_i[WIDTH-1]};
    // Extra bit keeps the shifted partial remainder exact; bit WIDTH of diff is the borrow.
    diff   = rem_sh - {1'b0, b_i};
    if (div_i) begin
      if (!diff[WIDTH]) begin
        acc_o = diff[WIDTH-1:0];
        q_o   = {q_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = rem_sh[WIDTH-1:0];
        q_o   = {q_i[WIDTH-2:0], 1'b0};
      end
    end else if (q_i[0]) begin
      {acc_o, q_o} = {sum, q_i[WIDTH-1:1]};
    end else begin
      {acc_o, q_o} = {1'b0, acc_i, q_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/DIV sequencer holding architectural HI/LO.
// Define MULDIV_UNSIGNED_EN to also accept MULTU/DIVU.
module muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Start,
  input  logic [1:0]       ALUOP,
  input  logic [5:0]       Function,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  import muldiv_pkg::*;

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  muldiv_state_t    state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, qr_q, qr_d, b_q, b_d, a_q, a_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic             is_div_q, is_div_d, dz_q, dz_d;
  logic             done_q, done_d, divzero_q, divzero_d;

  logic             fn_mul, fn_div, fn_signed, req_ok, sa, sb;
  logic [WIDTH-1:0] step_acc, step_q;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    fn_signed = (Function == FN_MULT) || (Function == FN_DIV);
`ifdef MULDIV_UNSIGNED_EN
    fn_mul = (Function == FN_MULT) || (Function == FN_MULTU);
    fn_div = (Function == FN_DIV) || (Function == FN_DIVU);
`else
    fn_mul = (Function == FN_MULT);
    fn_div = (Function == FN_DIV);
`endif
    req_ok = Start && (ALUOP == ALUOP_RTYPE) && (fn_mul || fn_div);
    sa     = fn_signed && OpA[WIDTH-1];
    sb     = fn_signed && OpB[WIDTH-1];
  end

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .div_i(state_q == DIV),
    .acc_i(acc_q),
    .q_i  (qr_q),
    .b_i  (b_q),
    .acc_o(step_acc),
    .q_o  (step_q)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    qr_d      = qr_q;
    b_d       = b_q;
    a_d       = a_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    is_div_d  = is_div_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    divzero_d = divzero_q;
    done_d    = 1'b0;
    prod      = {acc_q, qr_q};

    if (Flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_ok) begin
            cnt_d    = CntW'(WIDTH);
            acc_d    = '0;
            qr_d     = sa ? -OpA : OpA;
            b_d      = sb ? -OpB : OpB;
            a_d      = OpA;
            neg_lo_d = sa ^ sb;
            neg_hi_d = sa;
            is_div_d = fn_div;
            dz_d     = fn_div && (OpB == '0);
            if (!fn_div)         state_d = MUL;
            else if (OpB == '0)  state_d = FIX;
            else                 state_d = DIV;
          end
        end
        MUL, DIV: begin
          acc_d = step_acc;
          qr_d  = step_q;
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_d = FIX;
        end
        FIX: begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (!is_div_q) begin
            if (neg_lo_q) prod = -prod;
            {hi_d, lo_d} = prod;
            divzero_d    = 1'b0;
          end else if (dz_q) begin
            hi_d      = a_q;
            lo_d      = '1;
            divzero_d = 1'b1;
          end else begin
            // Most-negative / -1 wraps naturally to LO = most-negative, HI = 0.
            hi_d      = neg_hi_q ? -acc_q : acc_q;
            lo_d      = neg_lo_q ? -qr_q : qr_q;
            divzero_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      qr_q      <= '0;
      b_q       <= '0;
      a_q       <= '0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      is_div_q  <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      divzero_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      qr_q      <= qr_d;
      b_q       <= b_d;
      a_q       <= a_d;
      neg_lo_q  <= neg_lo_d;
      neg_hi_q  <= neg_hi_d;
      is_div_q  <= is_div_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      divzero_q <= divzero_d;
      done_q    <= done_d;
    end
  end

  assign Busy    = (state_q != IDLE);
  assign Done    = done_q;
  assign DivZero = divzero_q;
  assign HI      = hi_q;
  assign LO      = lo_q;

endmodule
